urv_csr_bank: RTL and testbench

- Parametrised CSR execute unit for the uRV core. It decodes the CSR op, computes the read-modify-write value and holds the read-only counters internally, with configurable counter width.
- Adds a configurable bank of scratch registers and a FIFO-based bidirectional debug mailbox with valid/ready handshakes on the debugger side.
- Sits in the X stage beside the ALU; trap CSRs (mstatus/mepc/mcause/mip/mie) arrive as inputs from the exception unit.

---
 rtl/urv_csr_bank_if.sv | 22 ++
 rtl/urv_csr_bank.sv | 200 ++++++++++++++++++++
 tb/tb_urv_csr_bank.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_csr_bank_if.sv
// Debug mailbox link between the external debugger and the CSR bank.
// rx flows debugger -> core, tx flows core -> debugger, each with valid/ready.
interface urv_csr_bank_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Debugger side.
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  // CSR bank side.
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/urv_csr_bank.sv
// uRV CSR execute unit: op decode, read-modify-write value, read-only counters,
// scratch register bank and an optional FIFO debug mailbox.
module urv_csr_bank #(
  parameter int unsigned g_counter_width  = 40,
  parameter int unsigned g_num_scratch    = 4,
  parameter int unsigned g_mbx_depth_log2 = 2,
  parameter int unsigned g_with_hw_debug  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_is_csr_i,
  input  logic [2:0]  d_fun_i,
  input  logic [4:0]  d_csr_imm_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] d_rs1_i,
  output logic [31:0] x_rd_o,
  output logic [31:0] x_csr_write_value_o,
  output logic        x_illegal_o,
  input  logic        time_tick_i,
  input  logic        instr_retire_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mip_i,
  input  logic [31:0] csr_mie_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mcause_i,
  urv_csr_bank_if.slave dbg
);

  localparam int unsigned W     = g_counter_width;
  localparam logic [1:0]  OpRw  = 2'd1;
  localparam logic [1:0]  OpRs  = 2'd2;
  localparam logic [1:0]  OpRc  = 2'd3;
  localparam logic [31:0] Mimpid = 32'h2024_0601;

  logic [W-1:0] cycle_q, time_q, instret_q;
  logic [63:0]  cycle_ext, time_ext, instret_ext;
  logic [31:0]  scratch_q [g_num_scratch];
  logic [g_num_scratch-1:0] scr_hit;

  logic [1:0]  op;
  logic [31:0] src;
  logic        wr_intent;
  logic        hit, ro;
  logic        commit;
  logic [31:0] mbx_rx_head, mbx_status;

  assign op          = d_fun_i[1:0];
  assign cycle_ext   = 64'(cycle_q);
  assign time_ext    = 64'(time_q);
  assign instret_ext = 64'(instret_q);

  // Read mux and address decode; ro marks CSRs that reject write-intent.
  always_comb begin
    x_rd_o  = 32'h0;
    hit     = 1'b0;
    ro      = 1'b0;
    scr_hit = '0;
    case (d_csr_sel_i)
      12'hC00: begin hit = 1'b1; ro = 1'b1; x_rd_o = cycle_ext[31:0];    end
      12'hC80: begin hit = 1'b1; ro = 1'b1; x_rd_o = cycle_ext[63:32];   end
      12'hC01: begin hit = 1'b1; ro = 1'b1; x_rd_o = time_ext[31:0];     end
      12'hC81: begin hit = 1'b1; ro = 1'b1; x_rd_o = time_ext[63:32];    end
      12'hC02: begin hit = 1'b1; ro = 1'b1; x_rd_o = instret_ext[31:0];  end
      12'hC82: begin hit = 1'b1; ro = 1'b1; x_rd_o = instret_ext[63:32]; end
      12'h300: begin hit = 1'b1; ro = 1'b1; x_rd_o = csr_mstatus_i;      end
      12'h304: begin hit = 1'b1; ro = 1'b1; x_rd_o = csr_mie_i;          end
      12'h341: begin hit = 1'b1; ro = 1'b1; x_rd_o = csr_mepc_i;         end
      12'h342: begin hit = 1'b1; ro = 1'b1; x_rd_o = csr_mcause_i;       end
      12'h344: begin hit = 1'b1; ro = 1'b1; x_rd_o = csr_mip_i;          end
      12'hF13: begin hit = 1'b1; ro = 1'b1; x_rd_o = Mimpid;             end
      12'h7D0: begin hit = 1'b1; x_rd_o = mbx_rx_head;                   end
      // Status is read-only except for RC/RCI, which clears the overflow flag.
      12'h7D1: begin hit = 1'b1; ro = (op != OpRc); x_rd_o = mbx_status; end
      default: ;
    endcase
    for (int i = 0; i < int'(g_num_scratch); i++) begin
      if (d_csr_sel_i == ((i == 0) ? 12'h340 : 12'h7C0 + 12'(i))) begin
        hit        = 1'b1;
        scr_hit[i] = 1'b1;
        x_rd_o     = scratch_q[i];
      end
    end
  end

  // Source operand, write-intent and read-modify-write result.
  always_comb begin
    src = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
    wr_intent = (op == OpRw) || (src != 32'h0);
    case (op)
      OpRw:    x_csr_write_value_o = src;
      OpRs:    x_csr_write_value_o = x_rd_o | src;
      OpRc:    x_csr_write_value_o = x_rd_o & ~src;
      default: x_csr_write_value_o = x_rd_o;
    endcase
  end

  assign x_illegal_o = d_is_csr_i & ((op == 2'd0) | ~hit | (ro & wr_intent));
  assign commit      = d_is_csr_i & ~x_stall_i & ~x_kill_i & ~x_illegal_o;

  // Free-running counters; they wrap naturally at 2^W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q   <= '0;
      time_q    <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + W'(1);
      if (time_tick_i)    time_q    <= time_q + W'(1);
      if (instr_retire_i) instret_q <= instret_q + W'(1);
    end
  end

  // Scratch bank loads the RMW result on a committed write-intent access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(g_num_scratch); i++) scratch_q[i] <= 32'h0;
    end else begin
      for (int i = 0; i < int'(g_num_scratch); i++) begin
        if (commit && wr_intent && scr_hit[i]) scratch_q[i] <= x_csr_write_value_o;
      end
    end
  end

  if (g_with_hw_debug != 0) begin : g_mbx
    localparam int unsigned     PtrW    = g_mbx_depth_log2;
    localparam int unsigned     Depth   = 1 << PtrW;
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(Depth);

    logic [31:0]     rx_mem [Depth];
    logic [31:0]     tx_mem [Depth];
    logic [PtrW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [PtrW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic            rx_ready_q, ovf_q;
    logic            rx_push, rx_pop, tx_push_req, tx_push, tx_pop, tx_full;
    logic            commit_data;

    assign commit_data = commit && (d_csr_sel_i == 12'h7D0);
    assign rx_push     = dbg.rx_valid & rx_ready_q;
    assign rx_pop      = commit_data && (rx_cnt_q != '0);
    assign tx_full     = (tx_cnt_q == CntFull);
    assign tx_pop      = (tx_cnt_q != '0) & dbg.tx_ready;
    assign tx_push_req = commit_data && (op == OpRw);
    // A same-cycle debugger pop frees the slot for a push into a full tx FIFO.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    // Next FIFO occupancy.
    always_comb begin
      rx_cnt_d = rx_cnt_q + (PtrW + 1)'(rx_push) - (PtrW + 1)'(rx_pop);
      tx_cnt_d = tx_cnt_q + (PtrW + 1)'(tx_push) - (PtrW + 1)'(tx_pop);
    end

    // FIFO pointers, counts, registered rx ready and sticky overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rx_wr_q    <= '0;
        rx_rd_q    <= '0;
        tx_wr_q    <= '0;
        tx_rd_q    <= '0;
        rx_cnt_q   <= '0;
        tx_cnt_q   <= '0;
        rx_ready_q <= 1'b1;
        ovf_q      <= 1'b0;
      end else begin
        if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
        if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
        if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
        rx_cnt_q   <= rx_cnt_d;
        tx_cnt_q   <= tx_cnt_d;
        rx_ready_q <= (rx_cnt_d != CntFull);
        if (tx_push_req && !tx_push) begin
          ovf_q <= 1'b1;
        end else if (commit && d_csr_sel_i == 12'h7D1 && op == OpRc && src[16]) begin
          ovf_q <= 1'b0;
        end
      end
    end

    // FIFO storage; contents are don't-care until the counts say otherwise.
    always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem[rx_wr_q] <= dbg.rx_data;
      if (tx_push) tx_mem[tx_wr_q] <= src;
    end

    assign dbg.rx_ready = rx_ready_q;
    assign dbg.tx_valid = (tx_cnt_q != '0);
    assign dbg.tx_data  = (tx_cnt_q != '0) ? tx_mem[tx_rd_q] : 32'h0;
    assign mbx_rx_head  = (rx_cnt_q != '0) ? rx_mem[rx_rd_q] : 32'h0;
    assign mbx_status   = {15'b0, ovf_q, 8'(tx_cnt_q), 8'(rx_cnt_q)};
  end else begin : g_no_mbx
    assign dbg.rx_ready = 1'b0;
    assign dbg.tx_valid = 1'b0;
    assign dbg.tx_data  = 32'h0;
    assign mbx_rx_head  = 32'h0;
    assign mbx_status   = 32'h0;
  end

endmodule

// File: tb/tb_urv_csr_bank.sv
// Directed bench for urv_csr_bank with a queue-based scoreboard and monitor.
module tb_urv_csr_bank;

  localparam logic [2:0] RW = 3'd1, RS = 3'd2, RC = 3'd3, RWI = 3'd5, RSI = 3'd6, RCI = 3'd7;
  localparam int SelRd = 0, SelIll = 1, SelWval = 2, SelRxRdy = 3, SelTxVld = 4, SelTxDat = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_stall = 1'b0, x_kill = 1'b0, d_is_csr = 1'b0;
  logic [2:0]  d_fun = 3'd0;
  logic [4:0]  d_imm = 5'd0;
  logic [11:0] d_sel = 12'h0;
  logic [31:0] d_rs1 = 32'h0;
  logic [31:0] x_rd, x_wval;
  logic        x_ill;
  logic        time_tick = 1'b0, instr_retire = 1'b0;
  logic [31:0] mstatus = 32'h0000_1888, mepc = 32'h8000_0100;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tx_q[$];

  urv_csr_bank_if dbg_if ();

  urv_csr_bank dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .x_stall_i           (x_stall),
    .x_kill_i            (x_kill),
    .d_is_csr_i          (d_is_csr),
    .d_fun_i             (d_fun),
    .d_csr_imm_i         (d_imm),
    .d_csr_sel_i         (d_sel),
    .d_rs1_i             (d_rs1),
    .x_rd_o              (x_rd),
    .x_csr_write_value_o (x_wval),
    .x_illegal_o         (x_ill),
    .time_tick_i         (time_tick),
    .instr_retire_i      (instr_retire),
    .csr_mstatus_i       (mstatus),
    .csr_mip_i           (32'h0000_0080),
    .csr_mie_i           (32'h0000_0888),
    .csr_mepc_i          (mepc),
    .csr_mcause_i        (32'h0000_000B),
    .dbg                 (dbg_if)
  );

  always #5 clk = ~clk;

  // Monitor: checks queued expectations and tx handshakes on the falling edge.
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sel)
        SelRd:    mon_act = x_rd;
        SelIll:   mon_act = {31'b0, x_ill};
        SelWval:  mon_act = x_wval;
        SelRxRdy: mon_act = {31'b0, dbg_if.rx_ready};
        SelTxVld: mon_act = {31'b0, dbg_if.tx_valid};
        default:  mon_act = dbg_if.tx_data;
      endcase
      nchk++;
      if (mon_act !== mon_e.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
    if (dbg_if.tx_valid === 1'b1 && dbg_if.tx_ready === 1'b1) begin
      nchk++;
      if (tx_q.size() == 0) begin
        nfail++;
        $display("FAIL tx_pop: got %h expected no pop", dbg_if.tx_data);
      end else begin
        mon_act = tx_q.pop_front();
        if (dbg_if.tx_data !== mon_act) begin
          nfail++;
          $display("FAIL tx_pop: got %h expected %h", dbg_if.tx_data, mon_act);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One CSR instruction for one cycle; ill is always checked, rd when chk_rd.
  task automatic csr_op(input logic [11:0] sel, input logic [2:0] fun, input logic [31:0] val,
                        input logic stall, input logic exp_ill, input logic chk_rd,
                        input logic [31:0] exp_rd, input string name);
    d_is_csr = 1'b1;
    d_sel    = sel;
    d_fun    = fun;
    d_rs1    = val;
    d_imm    = val[4:0];
    x_stall  = stall;
    expect_sig(SelIll, {31'b0, exp_ill}, {name, "/ill"});
    if (chk_rd) expect_sig(SelRd, exp_rd, {name, "/rd"});
    tick(1);
    d_is_csr = 1'b0;
    x_stall  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dbg_if.rx_data  = 32'h0;
    dbg_if.rx_valid = 1'b0;
    dbg_if.tx_ready = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state and counters.
    expect_sig(SelRxRdy, 32'd1, "rst_rx_ready");
    expect_sig(SelTxVld, 32'd0, "rst_tx_valid");
    expect_sig(SelTxDat, 32'd0, "rst_tx_data");
    csr_op(12'hC00, RS, 0, 0, 0, 1, 32'd0, "cycle_rst");
    tick(9);
    csr_op(12'hC00, RS, 0, 0, 0, 1, 32'd10, "cycle_10");
    csr_op(12'hC80, RS, 0, 0, 0, 1, 32'd0, "cycle_hi");
    csr_op(12'hC01, RS, 0, 0, 0, 1, 32'd0, "time_rst");
    csr_op(12'hC82, RS, 0, 0, 0, 1, 32'd0, "instret_hi_rst");
    time_tick = 1'b1;
    tick(3);
    time_tick = 1'b0;
    csr_op(12'hC01, RS, 0, 0, 0, 1, 32'd3, "time_3");
    instr_retire = 1'b1;
    tick(2);
    instr_retire = 1'b0;
    csr_op(12'hC02, RS, 0, 0, 0, 1, 32'd2, "instret_2");

    // Counter wrap at 2^40.
    dut.cycle_q = 40'hFF_FFFF_FFFE;
    csr_op(12'hC80, RS, 0, 0, 0, 1, 32'h0000_00FF, "cycle_hi_top");
    csr_op(12'hC00, RS, 0, 0, 0, 1, 32'hFFFF_FFFF, "cycle_lo_top");
    csr_op(12'hC00, RS, 0, 0, 0, 1, 32'd0, "cycle_lo_wrap");
    csr_op(12'hC80, RS, 0, 0, 0, 1, 32'd0, "cycle_hi_wrap");

    // Scratch bank.
    csr_op(12'h7C1, RW, 32'hA5A5_0000, 0, 0, 1, 32'h0, "scr1_rw");
    expect_sig(SelWval, 32'hA5A5_0003, "scr1_rsi_wval");
    csr_op(12'h7C1, RSI, 32'd3, 0, 0, 1, 32'hA5A5_0000, "scr1_rsi");
    csr_op(12'h7C1, RW, 32'h0000_DEAD, 1, 0, 1, 32'hA5A5_0003, "scr1_stall");
    csr_op(12'h7C1, RS, 0, 0, 0, 1, 32'hA5A5_0003, "scr1_after_stall");
    csr_op(12'h340, RW, 32'h0000_1234, 0, 0, 1, 32'h0, "mscratch_rw");
    csr_op(12'h340, RCI, 32'd4, 0, 0, 1, 32'h0000_1234, "mscratch_rci");
    csr_op(12'h340, RS, 0, 0, 0, 1, 32'h0000_1230, "mscratch_rd");
    csr_op(12'h7C3, RW, 32'h55, 0, 0, 1, 32'h0, "scr3_rw");
    csr_op(12'h7C4, RS, 0, 0, 1, 0, 32'h0, "scr4_unmapped");
    csr_op(12'h7C0, RS, 0, 0, 1, 0, 32'h0, "scr0_alias");

    // Illegal accesses.
    csr_op(12'hC00, RW, 32'd5, 0, 1, 0, 32'h0, "cycle_rw");
    csr_op(12'hC00, RS, 0, 0, 0, 0, 32'h0, "cycle_rs0");
    csr_op(12'h123, RS, 0, 0, 1, 0, 32'h0, "unmapped");
    csr_op(12'h7C1, 3'd4, 32'hFFFF, 0, 1, 0, 32'h0, "funct3_4");
    csr_op(12'h7C1, RS, 0, 0, 0, 1, 32'hA5A5_0003, "scr1_no_side_effect");
    csr_op(12'hF13, RS, 0, 0, 0, 1, 32'h2024_0601, "mimpid");
    csr_op(12'hF13, RWI, 0, 0, 1, 0, 32'h0, "mimpid_rw");
    csr_op(12'h300, RS, 0, 0, 0, 1, 32'h0000_1888, "mstatus");
    csr_op(12'h300, RSI, 32'd1, 0, 1, 0, 32'h0, "mstatus_rsi");
    csr_op(12'h341, RS, 0, 0, 0, 1, 32'h8000_0100, "mepc");

    // Mailbox rx: five pushes into a depth-4 FIFO.
    dbg_if.rx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dbg_if.rx_data = 32'h1000_0000 + 32'(k);
      tick(1);
    end
    dbg_if.rx_data = 32'h1000_0004;
    expect_sig(SelRxRdy, 32'd0, "rx_full_ready");
    tick(1);
    dbg_if.rx_valid = 1'b0;
    csr_op(12'h7D1, RS, 0, 0, 0, 1, 32'h0000_0004, "rx_status");
    for (int k = 0; k < 4; k++) begin
      csr_op(12'h7D0, RS, 0, 0, 0, 1, 32'h1000_0000 + 32'(k), "rx_pop");
    end
    csr_op(12'h7D0, RS, 0, 0, 0, 1, 32'h0, "rx_empty_rd");
    expect_sig(SelRxRdy, 32'd1, "rx_ready_again");
    tick(1);

    // Mailbox tx: overflow, drain, sticky flag clear.
    for (int k = 0; k < 5; k++) begin
      csr_op(12'h7D0, RW, 32'h2000_0000 + 32'(k), 0, 0, 1, 32'h0, "tx_push");
    end
    csr_op(12'h7D1, RS, 0, 0, 0, 1, 32'h0001_0400, "tx_ovf_status");
    for (int k = 0; k < 4; k++) tx_q.push_back(32'h2000_0000 + 32'(k));
    dbg_if.tx_ready = 1'b1;
    tick(5);
    dbg_if.tx_ready = 1'b0;
    expect_sig(SelTxVld, 32'd0, "tx_drained");
    csr_op(12'h7D1, RS, 0, 0, 0, 1, 32'h0001_0000, "ovf_sticky");
    csr_op(12'h7D1, RS, 32'h0001_0000, 0, 1, 0, 32'h0, "status_rs");
    csr_op(12'h7D1, RC, 32'h0001_0000, 0, 0, 1, 32'h0001_0000, "ovf_clear");
    csr_op(12'h7D1, RS, 0, 0, 0, 1, 32'h0, "ovf_cleared");

    // Push into a full tx FIFO while the debugger pops in the same cycle.
    for (int k = 0; k < 4; k++) begin
      csr_op(12'h7D0, RW, 32'h3000_0000 + 32'(k), 0, 0, 1, 32'h0, "tx_fill");
    end
    for (int k = 0; k < 5; k++) tx_q.push_back(32'h3000_0000 + 32'(k));
    dbg_if.tx_ready = 1'b1;
    csr_op(12'h7D0, RW, 32'h3000_0004, 0, 0, 1, 32'h0, "tx_push_on_pop");
    tick(4);
    dbg_if.tx_ready = 1'b0;
    csr_op(12'h7D1, RS, 0, 0, 0, 1, 32'h0, "tx_full_pop_status");

    // Reset mid-transfer discards rx contents.
    dbg_if.rx_valid = 1'b1;
    dbg_if.rx_data  = 32'hCAFE_0000;
    tick(2);
    dbg_if.rx_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    csr_op(12'h7D1, RS, 0, 0, 0, 1, 32'h0, "rst_mid_status");
    csr_op(12'h7C1, RS, 0, 0, 0, 1, 32'h0, "rst_scratch");

    tick(2);
    nchk++;
    if (tx_q.size() != 0 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL leftover: got %0d tx and %0d checks pending expected 0",
               tx_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
